lock_keypad_controller: RTL and testbench



---
 rtl/lock_pkg.sv | 21 ++
 rtl/lock_keypad_controller_if.sv | 37 +++
 rtl/lock_digit_buffer.sv | 60 ++++++
 rtl/lock_keypad_controller.sv | 148 ++++++++++++++
 tb/tb_lock_keypad_controller.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared encodings and default sizing for the keypad-to-lock sequencer.
package lock_pkg;

    localparam int              DEF_NUM_DIGITS = 4;
    localparam int              DEF_DIGIT_W    = 4;
    localparam logic [15:0]     DEF_CODE       = 16'h1234;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        CHECK   = 3'd1,
        ISSUE   = 3'd2,
        SETTLE  = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    typedef enum logic {
        OP_ENTER  = 1'b0,
        OP_CHANGE = 1'b1
    } op_t;

endpackage

// File: rtl/lock_keypad_controller_if.sv
// Keypad strobes, lock status and lock command/status outputs of the sequencer.
interface lock_keypad_controller_if import lock_pkg::*; #(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIGIT_W    = DEF_DIGIT_W
);
    localparam int CW = $clog2(NUM_DIGITS + 2);

    logic               key_valid;
    logic [DIGIT_W-1:0] key_digit;
    logic               key_enter;
    logic               key_change;
    logic               lock_open;
    logic               lock_new;
    logic               lock_alarm;
    logic               lock_correct;
    logic               lock_enter;
    logic               lock_change;
    logic               busy;
    logic [CW-1:0]      digit_count;
    logic               code_updated;
    logic               prog_error;

    modport master (
        output key_valid, key_digit, key_enter, key_change,
        output lock_open, lock_new, lock_alarm,
        input  lock_correct, lock_enter, lock_change,
        input  busy, digit_count, code_updated, prog_error
    );

    modport slave (
        input  key_valid, key_digit, key_enter, key_change,
        input  lock_open, lock_new, lock_alarm,
        output lock_correct, lock_enter, lock_change,
        output busy, digit_count, code_updated, prog_error
    );

endinterface

// File: rtl/lock_digit_buffer.sv
// Shift buffer of keyed digits with saturating count, overflow flag and idle timeout.
// Digit enters the LSBs one edge after shift; timeout clears after TIMEOUT_CYCLES idle edges.
module lock_digit_buffer #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_W        = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              shift,
    input  logic                              idle,
    input  logic [DIGIT_W-1:0]                digit,
    output logic [NUM_DIGITS*DIGIT_W-1:0]     buffer,
    output logic [$clog2(NUM_DIGITS+2)-1:0]   digit_count,
    output logic                              overflow
);
    localparam int BW = NUM_DIGITS * DIGIT_W;
    localparam int CW = $clog2(NUM_DIGITS + 2);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS + 1);

    logic [TW-1:0] timer;
    logic          expire;

    // A zero TIMEOUT_CYCLES never expires, so a partial entry is held indefinitely.
    assign expire = (TIMEOUT_CYCLES != 0) && idle && (digit_count != '0) &&
                    (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (!idle || (digit_count == '0) || expire) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buffer      <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
        end else if (clear || expire) begin
            buffer      <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
        end else if (shift) begin
            buffer <= {buffer[BW-DIGIT_W-1:0], digit};
            if (digit_count != FULL) begin
                digit_count <= digit_count + 1'b1;
            end
            if (digit_count == CW'(NUM_DIGITS)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lock_keypad_controller.sv
// Keypad sequencer: collects digits, compares against the code register, pulses the lock.
// Enter/change at edge k -> lock pulse in cycle k+2, keys accepted again from k+4; busy blocks keys.
module lock_keypad_controller import lock_pkg::*; #(
    parameter int                             NUM_DIGITS     = DEF_NUM_DIGITS,
    parameter int                             DIGIT_W        = DEF_DIGIT_W,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]  DEFAULT_CODE   = DEF_CODE,
    parameter int                             TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clock,
    input  logic                     reset,
    lock_keypad_controller_if.slave  bus
);
    localparam int BW = NUM_DIGITS * DIGIT_W;
    localparam int CW = $clog2(NUM_DIGITS + 2);

    state_t         state, state_nxt;
    op_t            op, op_nxt;
    logic [BW-1:0]  buffer, code;
    logic [CW-1:0]  digit_count;
    logic           overflow;
    logic           full_entry, match;
    logic           shift, clear, idle;
    logic           correct_nxt, enter_nxt, change_nxt, upd_nxt, err_nxt, busy_nxt;
    logic           lock_correct, lock_enter, lock_change, code_updated, prog_error, busy;

    assign full_entry = (digit_count == CW'(NUM_DIGITS)) && !overflow;
    assign match      = full_entry && (buffer == code);
    assign idle       = (state == COLLECT) &&
                        !(bus.key_enter || bus.key_change || bus.key_valid);

    lock_digit_buffer #(
        .NUM_DIGITS     (NUM_DIGITS),
        .DIGIT_W        (DIGIT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_buf (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .shift       (shift),
        .idle        (idle),
        .digit       (bus.key_digit),
        .buffer      (buffer),
        .digit_count (digit_count),
        .overflow    (overflow)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
            op    <= OP_ENTER;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
        end
    end

    // Pulse values are decided in CHECK so they are registered outputs during ISSUE.
    always_comb begin
        state_nxt   = state;
        op_nxt      = op;
        correct_nxt = 1'b0;
        enter_nxt   = 1'b0;
        change_nxt  = 1'b0;
        upd_nxt     = 1'b0;
        err_nxt     = 1'b0;
        shift       = 1'b0;
        clear       = 1'b0;
        case (state)
            COLLECT: begin
                if (bus.key_enter) begin
                    op_nxt    = OP_ENTER;
                    state_nxt = CHECK;
                end else if (bus.key_change) begin
                    op_nxt    = OP_CHANGE;
                    state_nxt = CHECK;
                end else if (bus.key_valid) begin
                    shift = 1'b1;
                end
            end
            CHECK: begin
                state_nxt = ISSUE;
                if (op == OP_CHANGE) begin
                    change_nxt  = 1'b1;
                    correct_nxt = match;
                end else if (bus.lock_new) begin
                    enter_nxt = 1'b1;
                    upd_nxt   = full_entry;
                    err_nxt   = !full_entry;
                end else begin
                    enter_nxt   = 1'b1;
                    correct_nxt = match;
                end
            end
            ISSUE:   state_nxt = SETTLE;
            SETTLE: begin
                clear     = 1'b1;
                state_nxt = COLLECT;
            end
            default: state_nxt = LOCKOUT;
        endcase
        // Alarm dominates every state and is only left through reset.
        if (bus.lock_alarm) begin
            state_nxt   = LOCKOUT;
            correct_nxt = 1'b0;
            enter_nxt   = 1'b0;
            change_nxt  = 1'b0;
            upd_nxt     = 1'b0;
            err_nxt     = 1'b0;
            shift       = 1'b0;
        end
        busy_nxt = (state_nxt != COLLECT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_correct <= 1'b0;
            lock_enter   <= 1'b0;
            lock_change  <= 1'b0;
            code_updated <= 1'b0;
            prog_error   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            lock_correct <= correct_nxt;
            lock_enter   <= enter_nxt;
            lock_change  <= change_nxt;
            code_updated <= upd_nxt;
            prog_error   <= err_nxt;
            busy         <= busy_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            code <= DEFAULT_CODE;
        end else if ((state == ISSUE) && code_updated) begin
            code <= buffer;
        end
    end

    assign bus.lock_correct = lock_correct;
    assign bus.lock_enter   = lock_enter;
    assign bus.lock_change  = lock_change;
    assign bus.code_updated = code_updated;
    assign bus.prog_error   = prog_error;
    assign bus.busy         = busy;
    assign bus.digit_count  = digit_count;

endmodule

// File: tb/tb_lock_keypad_controller.sv
// Directed bench: keypad sequences against a behavioural combination lock, hand-computed pulse patterns.
module tb_lock_keypad_controller;

    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    int   pulse_cnt = 0;
    int   p0;

    always #5 clock = ~clock;

    lock_keypad_controller_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus ();

    lock_keypad_controller #(
        .NUM_DIGITS     (4),
        .DIGIT_W        (4),
        .DEFAULT_CODE   (16'h1234),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Combination lock: two consecutive wrong attempts raise a sticky alarm.
    typedef enum logic [1:0] {L_LOCKED, L_OPEN, L_NEW, L_ALARM} lst_t;
    lst_t lst;
    int   wrong;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            lst   <= L_LOCKED;
            wrong <= 0;
        end else begin
            case (lst)
                L_LOCKED: if (bus.lock_enter || bus.lock_change) begin
                    if (bus.lock_correct) begin
                        lst   <= bus.lock_change ? L_NEW : L_OPEN;
                        wrong <= 0;
                    end else if (wrong >= 1) begin
                        lst <= L_ALARM;
                    end else begin
                        wrong <= wrong + 1;
                    end
                end
                L_OPEN, L_NEW: if (bus.lock_enter) lst <= L_LOCKED;
                default: ;
            endcase
        end
    end

    assign bus.lock_open  = (lst == L_OPEN);
    assign bus.lock_new   = (lst == L_NEW);
    assign bus.lock_alarm = (lst == L_ALARM);

    always @(negedge clock)
        if (bus.lock_enter || bus.lock_change || bus.lock_correct ||
            bus.code_updated || bus.prog_error)
            pulse_cnt++;

    function automatic logic [4:0] pulses();
        return {bus.lock_correct, bus.lock_enter, bus.lock_change,
                bus.code_updated, bus.prog_error};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic key(input bit e, input bit c, input bit v, input logic [3:0] d);
        @(negedge clock);
        bus.key_enter  = e;
        bus.key_change = c;
        bus.key_valid  = v;
        bus.key_digit  = d;
        @(negedge clock);
        bus.key_enter  = 1'b0;
        bus.key_change = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_digit  = 4'h0;
    endtask

    task automatic digits(input logic [31:0] seq, input int n);
        for (int i = 0; i < n; i++) key(1'b0, 1'b0, 1'b1, seq[(n-1-i)*4 +: 4]);
    endtask

    // Press enter/change, then check busy in k+1, pulses in k+2, quiet k+3, empty buffer k+4.
    task automatic fire(input bit c, input string tag, input logic [4:0] exp);
        key(!c, c, 1'b0, 4'h0);
        chk({tag, " busy@k+1"}, 32'(bus.busy), 32'd1);
        @(negedge clock);
        chk({tag, " pulses@k+2"}, 32'(pulses()), 32'(exp));
        @(negedge clock);
        chk({tag, " pulses@k+3"}, 32'(pulses()), 32'd0);
        @(negedge clock);
        chk({tag, " count@k+4"}, 32'(bus.digit_count), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.key_valid  = 1'b0;
        bus.key_digit  = 4'h0;
        bus.key_enter  = 1'b0;
        bus.key_change = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst busy",   32'(bus.busy), 32'd0);
        chk("rst count",  32'(bus.digit_count), 32'd0);
        chk("rst pulses", 32'(pulses()), 32'd0);
        reset = 1'b0;

        digits(32'h1234, 4);
        chk("count4", 32'(bus.digit_count), 32'd4);
        fire(1'b0, "open", 5'b11000);
        chk("open status", 32'(bus.lock_open), 32'd1);
        chk("idle busy", 32'(bus.busy), 32'd0);
        fire(1'b0, "empty relock", 5'b01000);
        chk("relocked", 32'(bus.lock_open), 32'd0);

        digits(32'h1235, 4);
        fire(1'b0, "wrong1", 5'b01000);
        chk("no alarm", 32'(bus.lock_alarm), 32'd0);
        digits(32'h1235, 4);
        fire(1'b0, "wrong2", 5'b01000);
        chk("alarm", 32'(bus.lock_alarm), 32'd1);
        chk("lockout busy", 32'(bus.busy), 32'd1);
        p0 = pulse_cnt;
        digits(32'h1234, 4);
        key(1'b1, 1'b0, 1'b0, 4'h0);
        repeat (4) @(negedge clock);
        chk("lockout pulses", 32'(pulse_cnt - p0), 32'd0);
        chk("lockout count", 32'(bus.digit_count), 32'd0);
        chk("lockout held", 32'(bus.busy), 32'd1);

        do_reset();
        chk("reset exits lockout", 32'(bus.busy), 32'd0);
        digits(32'h1234, 4);
        fire(1'b1, "change", 5'b10100);
        chk("new state", 32'(bus.lock_new), 32'd1);
        digits(32'h9876, 4);
        fire(1'b0, "program", 5'b01010);
        chk("new done", 32'(bus.lock_new), 32'd0);
        digits(32'h9876, 4);
        fire(1'b0, "new code", 5'b11000);
        fire(1'b0, "relock2", 5'b01000);
        digits(32'h1234, 4);
        fire(1'b0, "old code", 5'b01000);

        do_reset();
        digits(32'h1234, 4);
        fire(1'b1, "change2", 5'b10100);
        digits(32'h55, 2);
        fire(1'b0, "short prog", 5'b01001);
        chk("prog err idle", 32'(bus.lock_new), 32'd0);
        digits(32'h1234, 4);
        fire(1'b0, "code kept", 5'b11000);
        fire(1'b0, "relock3", 5'b01000);

        digits(32'h12344, 5);
        chk("count sat", 32'(bus.digit_count), 32'd5);
        fire(1'b0, "overflow", 5'b01000);

        digits(32'h1234, 4);
        key(1'b1, 1'b0, 1'b1, 4'h5);
        chk("enter wins count", 32'(bus.digit_count), 32'd4);
        @(negedge clock);
        chk("enter wins pulses", 32'(pulses()), 32'(5'b11000));
        repeat (2) @(negedge clock);
        fire(1'b0, "relock4", 5'b01000);

        p0 = pulse_cnt;
        digits(32'h12, 2);
        chk("tmo count2", 32'(bus.digit_count), 32'd2);
        repeat (7) @(negedge clock);
        chk("tmo not yet", 32'(bus.digit_count), 32'd2);
        @(negedge clock);
        chk("tmo cleared", 32'(bus.digit_count), 32'd0);
        chk("tmo no pulse", 32'(pulse_cnt - p0), 32'd0);

        digits(32'h1234, 4);
        key(1'b1, 1'b0, 1'b0, 4'h0);
        @(negedge clock);
        chk("issue enter", 32'(bus.lock_enter), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async rst pulses", 32'(pulses()), 32'd0);
        chk("async rst busy", 32'(bus.busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
